// File: rtl/skolem_sched_pkg.sv
// Shared types and defaults for the bit-serial Skolem scheduler.
package skolem_sched_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skolem_bitserial_sched_cell.sv
// Combinational 4-input Skolem cell; pure OR, no state, no flow control.
module skolem_cell (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  output logic i4
);

  assign i4 = i0 | i1 | i2 | i3;

endmodule

// File: rtl/skolem_bitserial_sched.sv
// Round-robin bit-serial Skolem scheduler; W-cycle latency, k+1 with SKOLEM_EARLY_TERM_EN.
// Grants only in IDLE; the response is held stable until rsp_ready.
module skolem_bitserial_sched
  import skolem_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_s,
  input  logic [NREQ*W-1:0]       req_t,
  input  logic [NREQ-1:0]         req_force,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [W-1:0]            rsp_x,
  output logic                    busy
);

  localparam int IDW = id_w(NREQ);
  localparam int KW  = (W > 1) ? $clog2(W) : 1;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [KW-1:0]  k_q, k_d;
  logic           carry_q, carry_d;
  logic           force_q, force_d;
  logic           vld_q, vld_d;
  logic [W-1:0]   s_q, s_d;
  logic [W-1:0]   t_q, t_d;
  logic [W-1:0]   x_q, x_d;

  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           win_vld;
  logic           cell_o;
  logic           term;

  // First valid requester at or after rr_q, wrapping.
  always_comb begin
    win     = '0;
    idx     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(rr_q) + i) % NREQ);
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  skolem_cell u_cell (
    .i0 (s_q[k_q]),
    .i1 (t_q[k_q]),
    .i2 (carry_q),
    .i3 (force_q),
    .i4 (cell_o)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    k_d     = k_q;
    carry_d = carry_q;
    force_d = force_q;
    vld_d   = vld_q;
    s_d     = s_q;
    t_d     = t_q;
    x_d     = x_q;
    term    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          s_d     = req_s[int'(win)*W +: W];
          t_d     = req_t[int'(win)*W +: W];
          force_d = req_force[win];
          id_d    = win;
          carry_d = 1'b0;
          k_d     = '0;
          x_d     = '0;
          rr_d    = IDW'((int'(win) + 1) % NREQ);
          state_d = EVAL;
        end
      end
      EVAL: begin
        x_d[k_q] = cell_o;
        carry_d  = cell_o;
        k_d      = k_q + 1'b1;
`ifdef SKOLEM_EARLY_TERM_EN
        // Once the carry is set every higher bit is one, so finish now.
        if (cell_o) begin
          x_d  = x_q | ({W{1'b1}} << k_q);
          term = 1'b1;
        end
`endif
        if (k_q == KW'(W - 1)) term = 1'b1;
        if (term) begin
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      force_q <= 1'b0;
      vld_q   <= 1'b0;
      s_q     <= '0;
      t_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      force_q <= force_d;
      vld_q   <= vld_d;
      s_q     <= s_d;
      t_q     <= t_d;
      x_q     <= x_d;
    end
  end

  assign req_ready = (state_q == IDLE && win_vld) ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_x     = x_q;
  assign busy      = (state_q != IDLE);

endmodule
